ones_chksum_stream: RTL and testbench

//  Streaming RFC1071 one's-complement checksum engine for IP/UDP/pseudo-header data on the
//  eth_udp byte path; synthesisable successor to the bench-only IP header checksum function.

---
 rtl/ones_chksum_stream.sv | 163 ++++++++++++++++
 tb/tb_ones_chksum_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_chksum_stream.sv
`default_nettype none
// ============================================================================
// Module   : ones_chksum_stream
// Purpose  : Streaming one's-complement (Internet) checksum engine. Accumulates
//            16-bit big-endian words from a byte stream of BYTES_PER_BEAT bytes
//            per beat, with odd lengths, partial last beats and a 16-bit seed
//            (pseudo-header sum). After the last beat, the accumulator is folded
//            twice and the result is presented for one cycle.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            inValid/inReady/inData/inKeep/inLast - input beat stream
//                            (byte0 in the MSBs, inKeep MSB = byte0)
//            seed          - initial sum, sampled on a packet's first beat
//            sumValid      - one-cycle result strobe
//            sum           - checksum to transmit (~folded sum)
//            sumOk         - folded sum == 0xFFFF (received data verifies)
//            protoErr      - one-cycle pulse: illegal inKeep on accepted beat
// Revision : 1.0 - initial release
// ============================================================================
module ones_chksum_stream #(
  parameter int BYTES_PER_BEAT = 1,
  parameter int ACC_W          = 32,
  parameter bit ZERO_AS_FFFF   = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [8*BYTES_PER_BEAT-1:0] inData,
  input  logic [BYTES_PER_BEAT-1:0]   inKeep,
  input  logic                        inLast,
  input  logic [15:0]                 seed,
  output logic                        sumValid,
  output logic [15:0]                 sum,
  output logic                        sumOk,
  output logic                        protoErr
);

  localparam int BPB = BYTES_PER_BEAT;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FOLD1 = 2'd1,
    FOLD2 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic             phase;      // parity of kept-byte count so far in packet
  logic             first;      // next accepted beat starts a new packet
  logic             accept;
  logic [ACC_W-1:0] beat_sum;
  logic             phase_nxt;
  logic             keep_bad;
  logic [ACC_W-1:0] fold_w;
  logic [15:0]      folded16;
  logic [15:0]      csum;

  assign accept = inValid && inReady;

  // Per-beat contribution. Only kept bytes advance the byte position, so an
  // illegal (holey) inKeep still sums exactly the bytes that were enabled.
  always_comb begin
    beat_sum  = '0;
    phase_nxt = first ? 1'b0 : phase;
    for (int i = 0; i < BPB; i++) begin
      if (inKeep[BPB-1-i]) begin
        if (!phase_nxt)
          beat_sum = beat_sum + ACC_W'({inData[8*(BPB-i)-1 -: 8], 8'h00});
        else
          beat_sum = beat_sum + ACC_W'(inData[8*(BPB-i)-1 -: 8]);
        phase_nxt = ~phase_nxt;
      end
    end
  end

  // Non-last beats must be full; the last beat must be MSB-contiguous.
  always_comb begin
    keep_bad = 1'b0;
    if (!inLast) begin
      keep_bad = (inKeep != {BPB{1'b1}});
    end else begin
      for (int i = 0; i < BPB-1; i++) begin
        if (inKeep[i] && !inKeep[i+1])
          keep_bad = 1'b1;
      end
    end
  end

  // End-around carry fold. Two folds always bring a 32-bit sum into 16 bits;
  // the second fold result fits in 16 bits, so its low half is the folded sum.
  assign fold_w   = ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]);
  assign folded16 = fold_w[15:0];

  always_comb begin
    csum = ~folded16;
    if (ZERO_AS_FFFF && (csum == 16'h0000))
      csum = 16'hFFFF;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ACCUM;
    else
      state <= state_nxt;
  end

  // Next state and handshake
  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    case (state)
      ACCUM: begin
        inReady = 1'b1;
        if (inValid && inLast)
          state_nxt = FOLD1;
      end
      FOLD1:   state_nxt = FOLD2;
      FOLD2:   state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      phase    <= 1'b0;
      first    <= 1'b1;
      sumValid <= 1'b0;
      sum      <= 16'h0000;
      sumOk    <= 1'b0;
      protoErr <= 1'b0;
    end else begin
      sumValid <= 1'b0;
      protoErr <= accept && keep_bad;
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= (first ? ACC_W'(seed) : acc) + beat_sum;
            phase <= phase_nxt;
            first <= 1'b0;
          end
        end
        FOLD1: begin
          acc <= fold_w;
        end
        FOLD2: begin
          sum      <= csum;
          sumOk    <= (folded16 == 16'hFFFF);
          sumValid <= 1'b1;
          acc      <= '0;
          phase    <= 1'b0;
          first    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ones_chksum_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_ones_chksum_stream
// Purpose  : Self-checking bench for ones_chksum_stream. Four instances
//            (1, 2, 4 bytes/beat, plus a 2-byte ZERO_AS_FFFF=1 copy sharing the
//            2-byte inputs) driven from a table of packets with hand-computed
//            checksums, plus directed sequences for back-to-back packets,
//            protoErr and reset aborts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ones_chksum_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] bdata;
  logic [7:0]  bkeep;
  logic        blast;
  logic [15:0] bseed;
  logic        v1, v2, v4;
  int          cur;

  logic r1, sv1, ok1, pe1;  logic [15:0] s1;
  logic r2, sv2, ok2, pe2;  logic [15:0] s2;
  logic r4, sv4, ok4, pe4;  logic [15:0] s4;
  logic rz, svz, okz, pez;  logic [15:0] sz;

  logic        o_rdy, o_sv, o_ok;
  logic [15:0] o_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ones_chksum_stream #(.BYTES_PER_BEAT(1), .ACC_W(32), .ZERO_AS_FFFF(1'b0)) u1 (
    .clk(clk), .rst(rst), .inValid(v1), .inReady(r1), .inData(bdata[63:56]),
    .inKeep(bkeep[7]), .inLast(blast), .seed(bseed), .sumValid(sv1), .sum(s1),
    .sumOk(ok1), .protoErr(pe1));

  ones_chksum_stream #(.BYTES_PER_BEAT(2), .ACC_W(32), .ZERO_AS_FFFF(1'b0)) u2 (
    .clk(clk), .rst(rst), .inValid(v2), .inReady(r2), .inData(bdata[63:48]),
    .inKeep(bkeep[7:6]), .inLast(blast), .seed(bseed), .sumValid(sv2), .sum(s2),
    .sumOk(ok2), .protoErr(pe2));

  ones_chksum_stream #(.BYTES_PER_BEAT(4), .ACC_W(32), .ZERO_AS_FFFF(1'b0)) u4 (
    .clk(clk), .rst(rst), .inValid(v4), .inReady(r4), .inData(bdata[63:32]),
    .inKeep(bkeep[7:4]), .inLast(blast), .seed(bseed), .sumValid(sv4), .sum(s4),
    .sumOk(ok4), .protoErr(pe4));

  ones_chksum_stream #(.BYTES_PER_BEAT(2), .ACC_W(24), .ZERO_AS_FFFF(1'b1)) uz (
    .clk(clk), .rst(rst), .inValid(v2), .inReady(rz), .inData(bdata[63:48]),
    .inKeep(bkeep[7:6]), .inLast(blast), .seed(bseed), .sumValid(svz), .sum(sz),
    .sumOk(okz), .protoErr(pez));

  always_comb begin
    case (cur)
      2:       begin o_rdy = r2; o_sv = sv2; o_sum = s2; o_ok = ok2; end
      4:       begin o_rdy = r4; o_sv = sv4; o_sum = s4; o_ok = ok4; end
      default: begin o_rdy = r1; o_sv = sv1; o_sum = s1; o_ok = ok1; end
    endcase
  end

  typedef struct {
    int           bpb;
    logic [159:0] data;   // right-aligned, byte0 is the most significant used byte
    int           len;
    logic [15:0]  sd;
    logic [15:0]  es;
    logic         eok;
    logic [15:0]  ez;     // expected sum of the ZERO_AS_FFFF copy (bpb==2 only)
  } vec_t;

  vec_t vecs [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_sum(output int lat);
    lat = 1;
    while (!o_sv && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send_pkt(input int bpb, input logic [159:0] data, input int len,
                          input logic [15:0] sd, output int lat);
    int          nb;
    int          idx;
    int          guard;
    logic [63:0] d;
    logic [7:0]  k;
    nb  = (len == 0) ? 1 : (len + bpb - 1) / bpb;
    cur = bpb;
    bseed = sd;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      d = '0;
      k = '0;
      for (int j = 0; j < bpb; j++) begin
        idx = b * bpb + j;
        if (idx < len) begin
          d[63-8*j -: 8] = data[8*(len-1-idx) +: 8];
          k[7-j] = 1'b1;
        end
      end
      bdata = d;
      bkeep = k;
      blast = (b == nb - 1);
      v1 = (bpb == 1);
      v2 = (bpb == 2);
      v4 = (bpb == 4);
      guard = 0;
      while (!o_rdy && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0; v4 = 1'b0; blast = 1'b0;
    wait_sum(lat);
  endtask

  task automatic count_sv(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (sv1) n++;
    end
  endtask

  localparam logic [159:0] T1A = 160'h4500007300004000_40110000C0A80001C0A800C7;
  localparam logic [159:0] T1B = 160'h4500007300004000_4011B861C0A80001C0A800C7;

  initial begin
    int   lat;
    int   n;
    logic [15:0] got_s;
    logic        got_ok;
    logic [15:0] got_z;

    vecs[0]  = '{1, T1A, 20, 16'h0000, 16'hB861, 1'b0, 16'h0000};
    vecs[1]  = '{1, T1B, 20, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[2]  = '{1, 160'h010203, 3, 16'h0000, 16'hFBFD, 1'b0, 16'h0000};
    vecs[3]  = '{1, 160'hAB, 1, 16'h0000, 16'h54FF, 1'b0, 16'h0000};
    vecs[4]  = '{1, 160'h0, 0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1, 160'hFFFF, 2, 16'h0001, 16'hFFFE, 1'b0, 16'h0000};
    vecs[6]  = '{4, 160'h010203, 3, 16'h0000, 16'hFBFD, 1'b0, 16'h0000};
    vecs[7]  = '{4, T1A, 20, 16'h0000, 16'hB861, 1'b0, 16'h0000};
    vecs[8]  = '{2, 160'hFFFFFFFF0001, 6, 16'h0000, 16'hFFFE, 1'b0, 16'hFFFE};
    vecs[9]  = '{2, 160'h0001, 2, 16'h1234, 16'hEDCA, 1'b0, 16'hEDCA};
    vecs[10] = '{2, 160'hFFFF, 2, 16'h0000, 16'h0000, 1'b1, 16'hFFFF};
    vecs[11] = '{2, T1A, 20, 16'h0000, 16'hB861, 1'b0, 16'hB861};
    vecs[12] = '{4, 160'h0102030405, 5, 16'h0000, 16'hF6F9, 1'b0, 16'h0000};
    vecs[13] = '{1, 160'h0102030405, 5, 16'h0000, 16'hF6F9, 1'b0, 16'h0000};

    rst = 1'b1; v1 = 1'b0; v2 = 1'b0; v4 = 1'b0; blast = 1'b0;
    bdata = '0; bkeep = '0; bseed = '0; cur = 1;
    repeat (3) @(negedge clk);
    chk("reset_ready_u1", {31'd0, r1}, 32'd1);
    chk("reset_sum_u4", {16'd0, s4}, 32'd0);
    chk("reset_flags_u2", {28'd0, sv2, ok2, pe2, rz}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven packets
    for (int v = 0; v < 14; v++) begin
      send_pkt(vecs[v].bpb, vecs[v].data, vecs[v].len, vecs[v].sd, lat);
      got_s  = o_sum;
      got_ok = o_ok;
      got_z  = sz;
      chk($sformatf("v%0d_latency", v), lat, 3);
      chk($sformatf("v%0d_sum", v), {16'd0, got_s}, {16'd0, vecs[v].es});
      chk($sformatf("v%0d_sumOk", v), {31'd0, got_ok}, {31'd0, vecs[v].eok});
      if (vecs[v].bpb == 2)
        chk($sformatf("v%0d_sum_zero_as_ffff", v), {16'd0, got_z}, {16'd0, vecs[v].ez});
      @(negedge clk);
      chk($sformatf("v%0d_strobe_one_cycle", v), {31'd0, o_sv}, 32'd0);
      chk($sformatf("v%0d_sum_held", v), {16'd0, o_sum}, {16'd0, vecs[v].es});
    end

    // Back-to-back packets with inValid held high (2 bytes/beat)
    cur = 2; bseed = 16'h0000;
    @(negedge clk);
    bdata = 64'h0102_0000_0000_0000; bkeep = 8'hC0; blast = 1'b1; v2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bdata = 64'h0304_0000_0000_0000;
    chk("b2b_fold1_not_ready", {31'd0, r2}, 32'd0);
    @(negedge clk);
    chk("b2b_fold2_not_ready", {31'd0, r2}, 32'd0);
    @(negedge clk);
    chk("b2b_first_valid", {31'd0, sv2}, 32'd1);
    chk("b2b_first_sum", {16'd0, s2}, 32'h0000FEFD);
    chk("b2b_ready_in_valid_cycle", {31'd0, r2}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0; blast = 1'b0;
    wait_sum(lat);
    chk("b2b_second_latency", lat, 3);
    chk("b2b_second_sum", {16'd0, s2}, 32'h0000FCFB);

    // Illegal inKeep on a non-last beat (4 bytes/beat); only kept bytes summed
    cur = 4;
    @(negedge clk);
    bdata = 64'h11223344_00000000; bkeep = 8'b0101_0000; blast = 1'b0; v4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("protoerr_pulse", {31'd0, pe4}, 32'd1);
    bdata = 64'h00000001_00000000; bkeep = 8'hF0; blast = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0; blast = 1'b0;
    chk("protoerr_clear_on_legal", {31'd0, pe4}, 32'd0);
    wait_sum(lat);
    chk("protoerr_pkt_sum", {16'd0, s4}, 32'h0000DDBA);

    // Reset during ACCUM: no result, engine back to reset state
    cur = 1;
    @(negedge clk);
    bdata = 64'h45 << 56; bkeep = 8'h80; blast = 1'b0; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bdata = 64'h00;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_accum_sum_cleared", {16'd0, s1}, 32'd0);
    count_sv(6, n);
    chk("rst_accum_no_valid", n, 0);

    // Reset during FOLD1
    @(negedge clk);
    bdata = 64'h12 << 56; bkeep = 8'h80; blast = 1'b1; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; blast = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_fold_ready", {31'd0, r1}, 32'd1);
    count_sv(6, n);
    chk("rst_fold_no_valid", n, 0);

    send_pkt(1, T1A, 20, 16'h0000, lat);
    chk("after_rst_latency", lat, 3);
    chk("after_rst_sum", {16'd0, o_sum}, 32'h0000B861);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
